// File: rtl/sg_rx_req_gen.sv
// sg_rx_req_gen
// Walks scatter-gather elements and issues PCIe read requests. Each request is
// bounded by the max read size, the 4 KB page boundary, the remaining element
// length, the remaining transfer length and the receive FIFO credit.
module sg_rx_req_gen #(
    parameter logic [2:0]  C_MAX_READ_REQ = 3'd2,
    parameter int unsigned C_FIFO_DEPTH   = 1024,
    parameter logic [1:0]  C_TAG          = 2'b00
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [2:0]  CONFIG_MAX_READ_REQUEST_SIZE,
    input  logic        XFER_START,
    input  logic [31:0] XFER_LEN,
    input  logic        XFER_ABORT,
    output logic        XFER_DONE,
    input  logic [63:0] SG_ELEM_ADDR,
    input  logic [31:0] SG_ELEM_LEN,
    input  logic        SG_ELEM_RDY,
    output logic        SG_ELEM_REN,
    output logic        RX_REQ,
    input  logic        RX_REQ_ACK,
    output logic [1:0]  RX_REQ_TAG,
    output logic [63:0] RX_REQ_ADDR,
    output logic [9:0]  RX_REQ_LEN,
    input  logic [3:0]  CPL_WORDS
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CALC,
        S_REQ,
        S_DONE
    } state_t;

    localparam logic [31:0] FIFO_DEPTH = 32'(C_FIFO_DEPTH);

    state_t      rState;
    state_t      next_state;

    logic [31:0] rRemain;
    logic [63:0] rElemAddr;
    logic [31:0] rElemLen;
    logic [10:0] rOutstanding;
    logic [63:0] rReqAddr;
    logic [9:0]  rReqLen;

    logic [2:0]  size_code;
    logic [31:0] max_words;
    logic [31:0] bound_words;
    logic [31:0] calc_len;
    logic        credit_ok;
    logic        elem_pop;
    logic        ack_take;
    logic [11:0] out_sum;
    logic [10:0] out_next;

    // Request length: smallest of element, transfer, read-size cap and page room.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        size_code = CONFIG_MAX_READ_REQUEST_SIZE;
        if (C_MAX_READ_REQ < size_code) size_code = C_MAX_READ_REQ;
        if (size_code > 3'd4)           size_code = 3'd4;
        max_words   = 32'd32 << size_code;
        // Words left before the next 4 KB boundary (1..1024).
        bound_words = 32'd1024 - {22'd0, rElemAddr[11:2]};
        calc_len = rElemLen;
        if (rRemain     < calc_len) calc_len = rRemain;
        if (max_words   < calc_len) calc_len = max_words;
        if (bound_words < calc_len) calc_len = bound_words;
        credit_ok = ({21'd0, rOutstanding} + calc_len) <= FIFO_DEPTH;
    end

    // Next-state decode; abort overrides everything and suppresses a same-cycle ACK.
    always_comb begin
        next_state = rState;
        elem_pop   = 1'b0;
        ack_take   = 1'b0;
        case (rState)
            S_IDLE: begin
                if (XFER_START) next_state = (XFER_LEN == 32'd0) ? S_DONE : S_FETCH;
            end
            S_FETCH: begin
                if (SG_ELEM_RDY) begin
                    elem_pop   = 1'b1;
                    next_state = S_CALC;
                end
            end
            S_CALC: begin
                if (rElemLen == 32'd0)  next_state = S_FETCH;
                else if (credit_ok)     next_state = S_REQ;
            end
            S_REQ: begin
                if (RX_REQ_ACK) begin
                    ack_take = 1'b1;
                    if (rRemain == {22'd0, rReqLen})       next_state = S_DONE;
                    else if (rElemLen == {22'd0, rReqLen}) next_state = S_FETCH;
                    else                                   next_state = S_CALC;
                end
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
        if (XFER_ABORT) begin
            next_state = S_IDLE;
            ack_take   = 1'b0;
        end
    end

    // Outstanding credit: add accepted words, subtract completions, floor at zero.
    always_comb begin
        out_sum  = {1'b0, rOutstanding} + (ack_take ? {2'b00, rReqLen} : 12'd0);
        out_next = 11'd0;
        if (out_sum > {8'd0, CPL_WORDS}) out_next = 11'(out_sum - {8'd0, CPL_WORDS});
    end

    // State register.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (RST) rState <= S_IDLE;
        else     rState <= next_state;
    end

    // Transfer, element, request and credit registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rRemain      <= '0;
            rElemAddr    <= '0;
            rElemLen     <= '0;
            rOutstanding <= '0;
            rReqAddr     <= '0;
            rReqLen      <= '0;
        end else begin
            if (rState == S_IDLE && XFER_START && !XFER_ABORT) rRemain <= XFER_LEN;
            if (elem_pop && !XFER_ABORT) begin
                rElemAddr <= SG_ELEM_ADDR;
                rElemLen  <= SG_ELEM_LEN;
            end
            // Request fields only move in CALC, so they hold steady while RX_REQ is up.
            if (rState == S_CALC && !XFER_ABORT) begin
                rReqAddr <= rElemAddr;
                rReqLen  <= calc_len[9:0];
            end
            if (ack_take) begin
                rElemAddr <= rElemAddr + {52'd0, rReqLen, 2'b00};
                rElemLen  <= rElemLen - {22'd0, rReqLen};
                rRemain   <= rRemain - {22'd0, rReqLen};
            end
            rOutstanding <= out_next;
        end
    end

    assign SG_ELEM_REN = elem_pop;
    assign RX_REQ      = (rState == S_REQ);
    assign XFER_DONE   = (rState == S_DONE);
    assign RX_REQ_TAG  = C_TAG;
    assign RX_REQ_ADDR = rReqAddr;
    assign RX_REQ_LEN  = rReqLen;

endmodule
